// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the priority arbiter (slave).
interface priority_arbiter_if;
  logic       en;
  logic       rr_mode;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic       busy;

  modport master (
    output en, rr_mode, req, done,
    input  gnt, gnt_id, gnt_valid, timeout, busy
  );

  modport slave (
    input  en, rr_mode, req, done,
    output gnt, gnt_id, gnt_valid, timeout, busy
  );
endinterface

// File: rtl/priority_arbiter.sv
// 8-way arbiter with fixed or round-robin selection, grant timeout and a one-cycle
// recovery gap between grants. All outputs come straight from registers.
module priority_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} stateE;

  // Counter is wide enough to reach TIMEOUT; with TIMEOUT=0 it just saturates unused.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CMAX   = '1;

  stateE         state_q, state_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [2:0]    gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic [2:0]    last_id_q, last_id_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0] fixedWin, rrWin, win, idx;
  logic       expire, release_ev;

  // Winner search; the round-robin loop runs from the farthest offset down so the
  // nearest asserted bit after last_id overwrites the rest.
  always_comb begin
    fixedWin = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req[i]) fixedWin = 3'(i);
    end
    rrWin = 3'd0;
    idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = last_id_q + 3'd1 + 3'(k);
      if (bus.req[idx]) rrWin = idx;
    end
    win = bus.rr_mode ? rrWin : fixedWin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 8'd0;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      last_id_q   <= 3'd7;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      last_id_q   <= last_id_d;
      cnt_q       <= cnt_d;
    end
  end

  // Done outranks expiry, so a coincident done suppresses the timeout pulse.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    last_id_d   = last_id_q;
    cnt_d       = cnt_q;
    expire      = (TIMEOUT != 0) && (cnt_q == TLIMIT);
    release_ev  = bus.done || !bus.req[gnt_id_q] || expire;

    case (state_q)
      IDLE: begin
        if (bus.en && (bus.req != 8'd0)) begin
          state_d     = GRANT;
          gnt_d       = 8'd1 << win;
          gnt_id_d    = win;
          gnt_valid_d = 1'b1;
          last_id_d   = win;
          cnt_d       = CW'(1);
        end
      end
      GRANT: begin
        if (release_ev) begin
          state_d     = RECOVER;
          gnt_d       = 8'd0;
          gnt_id_d    = 3'd0;
          gnt_valid_d = 1'b0;
          timeout_d   = expire && !bus.done;
          cnt_d       = '0;
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'd0;
        gnt_id_d    = 3'd0;
        gnt_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: maximum cycles a grant is held; 0 disables the timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: arbitration enable; when low, no new grant is issued.
REQ-005 The block SHALL have port rr_mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin.
REQ-006 The block SHALL have port req, input, 8 bits: one request line per requester, level-held until served.
REQ-007 The block SHALL have port done, input, 1 bit: release strobe from the current owner.
REQ-008 The block SHALL have port gnt, output, 8 bits: one-hot grant, all zero when no grant.
REQ-009 The block SHALL have port gnt_id, output, 3 bits: binary index of the granted requester.
REQ-010 The block SHALL have port gnt_valid, output, 1 bit: high while any grant is active.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by expiry.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL implement exactly three states, IDLE, GRANT and RECOVER, with all outputs registered.
REQ-014 In IDLE, with en=1 and req nonzero, the block SHALL select a winner and enter GRANT, with gnt, gnt_id and gnt_valid asserted one cycle after req is sampled.
REQ-015 In fixed mode the highest-index asserted req bit SHALL win; bit 7 has highest priority and bit 0 the lowest.
REQ-016 In round-robin mode the search SHALL start at (last_id+1) mod 8 and ascend with wrap-around, and the first asserted bit SHALL win.
REQ-017 last_id SHALL update to the winner on every grant in either mode, and SHALL reset to 7 so that the first round-robin search starts at 0.
REQ-018 rr_mode SHALL be sampled only in IDLE at the arbitration cycle; changes during GRANT SHALL NOT affect the current owner.
REQ-019 In GRANT, gnt, gnt_id and gnt_valid SHALL hold constant until one of three release events occurs:
- done=1;
- req[gnt_id]=0;
- cycle counter reaches TIMEOUT (TIMEOUT nonzero).
REQ-020 On any release event the block SHALL clear gnt, gnt_valid and gnt_id to 0 on the next edge and enter RECOVER.
REQ-021 If timeout expiry and done coincide in the same cycle, done SHALL take priority and timeout SHALL NOT pulse.
REQ-022 The cycle counter SHALL start at 1 in the first GRANT cycle and saturate, never wrapping; its width SHALL be sufficient for TIMEOUT.
REQ-023 On expiry release the timeout output SHALL pulse high for exactly one cycle, coincident with the RECOVER cycle.
REQ-024 RECOVER SHALL last exactly one cycle with no grant active, then enter IDLE, giving at least one dead cycle between consecutive grants.
REQ-025 Deasserting en during GRANT SHALL NOT revoke the current grant; only new arbitration SHALL be blocked.
REQ-026 done asserted outside GRANT SHALL be ignored.
REQ-027 gnt SHALL always be one-hot or zero, and gnt_id SHALL always equal the index of the set gnt bit, or 0 when none is set.

Reset
REQ-028 While rst_n=0 the block SHALL force state IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, busy=0, last_id=7 and counter=0, independent of clk.
REQ-029 Reset asserted mid-grant SHALL drop the grant immediately, and the first arbitration after rst_n rises SHALL occur no earlier than the first rising clk edge.

Verification
REQ-030 The bench SHALL cover fixed-mode priority: rr_mode=0, req=8'b1010_0100 -> gnt=8'b1000_0000 and gnt_id=7 one cycle later; after done, RECOVER, then gnt=8'b0010_0000 and gnt_id=5.
REQ-031 The bench SHALL cover round-robin order: rr_mode=1, req=8'hFF held, each grant released by done -> grant sequence 0,1,2,...,7,0, with exactly one idle cycle between grants.
REQ-032 The bench SHALL cover timeout: TIMEOUT=4, req=8'h01 held, done=0 -> gnt_valid high for 4 cycles, then low with timeout=1 for one cycle; regrant to 0 occurs after RECOVER.
REQ-033 The bench SHALL cover done colliding with expiry: done=1 in the 4th GRANT cycle with TIMEOUT=4 -> release with timeout remaining 0.
REQ-034 The bench SHALL cover en behaviour:
- en=0 with req=8'h10 -> no grant while en stays low;
- en raised -> gnt_id=4 next cycle;
- en dropped mid-grant -> grant held until done.
REQ-035 The bench SHALL cover asynchronous reset: rst_n pulsed low between clock edges during GRANT -> all outputs 0 immediately; after release, rr_mode=1 with req=8'h81 -> gnt_id=0.
